// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_stack_unit
// Brief    : Fetch-stage program counter with increment, jump, relative branch
//            and a hardware call/return stack with sticky over/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module pc_stack_unit #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned RESET_VEC   = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic [2:0]                       op,
    input  logic [ADDR_W-1:0]                target,
    input  logic [ADDR_W-1:0]                offset,
    input  logic                             clr_err,
    output logic [ADDR_W-1:0]                pc_count,
    output logic [ADDR_W-1:0]                ret_addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             ovf_err,
    output logic                             unf_err
);

    localparam int unsigned c_DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned c_IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [ADDR_W-1:0]    c_RESET_PC = ADDR_W'(RESET_VEC);
    localparam logic [c_DEPTH_W-1:0] c_FULL     = c_DEPTH_W'(STACK_DEPTH);
    localparam logic [c_DEPTH_W-1:0] c_ONE      = c_DEPTH_W'(1);

    localparam logic [2:0] c_OP_HOLD   = 3'b000;
    localparam logic [2:0] c_OP_INC    = 3'b001;
    localparam logic [2:0] c_OP_JUMP   = 3'b010;
    localparam logic [2:0] c_OP_BRANCH = 3'b011;
    localparam logic [2:0] c_OP_CALL   = 3'b100;
    localparam logic [2:0] c_OP_RET    = 3'b101;

    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    r_stack [STACK_DEPTH];
    logic [c_DEPTH_W-1:0] r_depth;
    logic                 r_ovf;
    logic                 r_unf;

    logic                 w_full;
    logic                 w_empty;
    logic [c_IDX_W-1:0]   w_top_idx;
    logic [c_IDX_W-1:0]   w_push_idx;
    logic [ADDR_W-1:0]    w_pc_inc;
    logic [ADDR_W-1:0]    w_pc_nxt;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_set_ovf;
    logic                 w_set_unf;

    assign w_full     = (r_depth == c_FULL);
    assign w_empty    = (r_depth == '0);
    assign w_top_idx  = c_IDX_W'(r_depth - c_ONE);
    assign w_push_idx = c_IDX_W'(r_depth);
    assign w_pc_inc   = r_pc + ADDR_W'(1);

    // Decode the op into next PC plus push/pop/fault strobes; stall masks all.
    always_comb begin
        w_pc_nxt  = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (en) begin
            case (op)
                c_OP_HOLD:   w_pc_nxt = r_pc;
                c_OP_INC:    w_pc_nxt = w_pc_inc;
                c_OP_JUMP:   w_pc_nxt = target;
                // Two's-complement add wraps naturally in ADDR_W bits.
                c_OP_BRANCH: w_pc_nxt = r_pc + offset;
                c_OP_CALL: begin
                    if (w_full) begin
                        w_set_ovf = 1'b1;
                    end else begin
                        w_push   = 1'b1;
                        w_pc_nxt = target;
                    end
                end
                c_OP_RET: begin
                    if (w_empty) begin
                        w_set_unf = 1'b1;
                    end else begin
                        w_pop    = 1'b1;
                        w_pc_nxt = r_stack[w_top_idx];
                    end
                end
                default:     w_pc_nxt = r_pc;
            endcase
        end
    end

    // PC, stack pointer and return-address storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= c_RESET_PC;
            r_depth <= '0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_pc <= w_pc_nxt;
            if (w_push) begin
                r_stack[w_push_idx] <= w_pc_inc;
                r_depth             <= r_depth + c_ONE;
            end else if (w_pop) begin
                r_depth <= r_depth - c_ONE;
            end
        end
    end

    // Sticky error flags: a fault in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_set_ovf | (r_ovf & ~clr_err);
            r_unf <= w_set_unf | (r_unf & ~clr_err);
        end
    end

    assign pc_count    = r_pc;
    assign ret_addr    = w_empty ? '0 : r_stack[w_top_idx];
    assign depth       = r_depth;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign ovf_err     = r_ovf;
    assign unf_err     = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_stack_unit
// Brief    : Directed plus randomized bench for pc_stack_unit against a
//            queue-based reference model (ADDR_W=5, STACK_DEPTH=4, RESET_VEC=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_stack_unit;

    localparam int c_AW   = 5;
    localparam int c_SD   = 4;
    localparam int c_MOD  = 32;
    localparam int c_RVEC = 0;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [2:0]       op;
    logic [c_AW-1:0]  target;
    logic [c_AW-1:0]  offset;
    logic             clr_err;
    logic [c_AW-1:0]  pc_count;
    logic [c_AW-1:0]  ret_addr;
    logic [2:0]       depth;
    logic             stack_full;
    logic             stack_empty;
    logic             ovf_err;
    logic             unf_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pc;
    int m_stk[$];
    bit m_ovf;
    bit m_unf;

    pc_stack_unit #(
        .ADDR_W      (c_AW),
        .STACK_DEPTH (c_SD),
        .RESET_VEC   (c_RVEC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .op          (op),
        .target      (target),
        .offset      (offset),
        .clr_err     (clr_err),
        .pc_count    (pc_count),
        .ret_addr    (ret_addr),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = c_RVEC;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Architectural behaviour of one clock edge.
    task automatic model_step(input bit e, input int o, input int t, input int f, input bit c);
        int soff;
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (e) begin
            case (o)
                1: m_pc = (m_pc + 1) % c_MOD;
                2: m_pc = t;
                3: begin
                    soff = (f >= c_MOD / 2) ? f - c_MOD : f;
                    m_pc = (m_pc + soff + c_MOD) % c_MOD;
                end
                4: begin
                    if (m_stk.size() == c_SD) m_ovf = 1'b1;
                    else begin
                        m_stk.push_back((m_pc + 1) % c_MOD);
                        m_pc = t;
                    end
                end
                5: begin
                    if (m_stk.size() == 0) m_unf = 1'b1;
                    else m_pc = m_stk.pop_back();
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        int exp_ret;
        exp_ret = (m_stk.size() == 0) ? 0 : m_stk[$];
        check({tag, ".pc"},    32'(pc_count),    32'(m_pc));
        check({tag, ".ret"},   32'(ret_addr),    32'(exp_ret));
        check({tag, ".depth"}, 32'(depth),       32'(m_stk.size()));
        check({tag, ".full"},  32'(stack_full),  32'(m_stk.size() == c_SD));
        check({tag, ".empty"}, 32'(stack_empty), 32'(m_stk.size() == 0));
        check({tag, ".ovf"},   32'(ovf_err),     32'(m_ovf));
        check({tag, ".unf"},   32'(unf_err),     32'(m_unf));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare with the model.
    task automatic step(input string tag, input bit e, input int o, input int t,
                        input int f, input bit c);
        en      = e;
        op      = 3'(o);
        target  = c_AW'(t);
        offset  = c_AW'(f);
        clr_err = c;
        @(posedge clk);
        #1;
        model_step(e, o, t, f, c);
        check_all(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        op      = 3'd0;
        target  = '0;
        offset  = '0;
        clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Increment across the wrap point
        for (int i = 0; i < 33; i++) begin
            step("inc", 1, 1, 0, 0, 0);
            check("inc_seq", 32'(pc_count), 32'((i + 1) % 32));
        end

        // Relative branch, backward and forward with wrap
        step("jmp3", 1, 2, 3, 0, 0);
        step("br_neg", 1, 3, 0, 5'b11110, 0);
        check("br_neg_lit", 32'(pc_count), 32'd1);
        step("jmp30", 1, 2, 30, 0, 0);
        step("br_wrap", 1, 3, 0, 5'b00101, 0);
        check("br_wrap_lit", 32'(pc_count), 32'd3);

        // Nested call/return
        step("jmp2", 1, 2, 2, 0, 0);
        step("call10", 1, 4, 10, 0, 0);
        check("call10_ret", 32'(ret_addr), 32'd3);
        step("call20", 1, 4, 20, 0, 0);
        check("call20_ret", 32'(ret_addr), 32'd11);
        step("ret1", 1, 5, 0, 0, 0);
        check("ret1_pc", 32'(pc_count), 32'd11);
        step("ret2", 1, 5, 0, 0, 0);
        check("ret2_pc", 32'(pc_count), 32'd3);
        check("ret2_empty", 32'(stack_empty), 32'd1);

        // Overflow on a full stack, then clear while stalled
        for (int i = 0; i < 4; i++) step("fill", 1, 4, 12 + i, 0, 0);
        check("fill_full", 32'(stack_full), 32'd1);
        step("ovf_call", 1, 4, 7, 0, 0);
        check("ovf_pc", 32'(pc_count), 32'd15);
        check("ovf_flag", 32'(ovf_err), 32'd1);
        step("ovf_clr", 0, 4, 7, 0, 1);
        check("ovf_cleared", 32'(ovf_err), 32'd0);

        // Underflow, stall, and set-beats-clear
        for (int i = 0; i < 4; i++) step("drain", 1, 5, 0, 0, 0);
        step("unf_ret", 1, 5, 0, 0, 0);
        check("unf_flag", 32'(unf_err), 32'd1);
        step("stall_jmp", 0, 2, 9, 0, 0);
        step("unf_set_clr", 1, 5, 0, 0, 1);
        check("unf_set_wins", 32'(unf_err), 32'd1);
        step("unf_clr", 1, 0, 0, 0, 1);

        // Asynchronous reset with three entries on the stack
        for (int i = 0; i < 3; i++) step("pre_rst", 1, 4, 4 + i, 0, 0);
        step("pre_rst_ovf", 0, 0, 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2;
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 9) != 0),
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)),
                 ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
